tta_fu_array: RTL and testbench

//  Parametrised array of NFU transport-triggered function units fed by NBUS parallel move buses.

---
 rtl/tta_fu_array.sv | 174 +++++++++++++++++
 tb/tb_tta_fu_array.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tta_fu_array.sv
// tta_fu_array: NFU transport-triggered function units fed by NBUS move buses.
// Each FU has an operand register O and a trigger port T. A move to T starts
// result = O op T. The result travels through an LAT-stage pipeline into the
// result register R.
//
// Ports (top):
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   stall           freezes pipelines; moves are ignored while high
//   mv_valid/dst/op/data   per-bus move; dst = {fu_idx, port}, port 0=O, 1=T
//   mv_ready        = ~stall
//   rd_en           per-FU result consume
//   res_data/valid  per-FU R register and its "unconsumed" flag
//   busy            per-FU: an op is in flight
//   conflict        one-cycle pulse: two valid buses named the same destination
//   overrun         per-FU sticky: an unconsumed result was overwritten

// Per-FU datapath: operand register, ALU, valid/data shift pipeline, R register.
module tta_fu #(
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          op_we,
  input  logic [DW-1:0] op_wdata,
  input  logic          trig_we,
  input  logic [2:0]    trig_op,
  input  logic [DW-1:0] trig_data,
  input  logic          rd_en,
  output logic [DW-1:0] res_data,
  output logic          res_valid,
  output logic          busy,
  output logic          overrun
);
  localparam int SHW = $clog2(DW);

  logic [DW-1:0]           opnd_q, opnd, alu_res;
  logic [LAT-1:0]          vld_pipe;
  logic [LAT-1:0][DW-1:0]  dat_pipe;
  logic                    retire;

  // Same-cycle operand move bypasses the register into the trigger.
  assign opnd   = op_we ? op_wdata : opnd_q;
  assign retire = vld_pipe[LAT-1] & ~stall;
  assign busy   = |vld_pipe;

  always_comb begin
    alu_res = '0;
    case (trig_op)
      3'd0: alu_res = opnd + trig_data;
      3'd1: alu_res = opnd - trig_data;
      3'd2: alu_res = opnd & trig_data;
      3'd3: alu_res = opnd | trig_data;
      3'd4: alu_res = opnd ^ trig_data;
      3'd5: alu_res = opnd << trig_data[SHW-1:0];
      3'd6: alu_res = opnd >> trig_data[SHW-1:0];
      3'd7: alu_res = {{(DW-1){1'b0}}, $signed(opnd) < $signed(trig_data)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q    <= '0;
      vld_pipe  <= '0;
      dat_pipe  <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (op_we) opnd_q <= op_wdata;
      if (!stall) begin
        vld_pipe[0] <= trig_we;
        dat_pipe[0] <= alu_res;
        for (int j = 1; j < LAT; j++) begin
          vld_pipe[j] <= vld_pipe[j-1];
          dat_pipe[j] <= dat_pipe[j-1];
        end
      end
      // A retire wins over rd_en; overwriting an unread result is recorded.
      if (retire) begin
        res_data  <= dat_pipe[LAT-1];
        res_valid <= 1'b1;
        if (res_valid && !rd_en) overrun <= 1'b1;
      end else if (rd_en) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

module tta_fu_array #(
  parameter int NBUS = 2,
  parameter int NFU  = 4,
  parameter int DW   = 32,
  parameter int LAT  = 2,
  parameter int DSTW = $clog2(NFU) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic [NBUS-1:0]                mv_valid,
  input  logic [NBUS-1:0][DSTW-1:0]      mv_dst,
  input  logic [NBUS-1:0][2:0]           mv_op,
  input  logic [NBUS-1:0][DW-1:0]        mv_data,
  output logic                           mv_ready,
  input  logic [NFU-1:0]                 rd_en,
  output logic [NFU-1:0][DW-1:0]         res_data,
  output logic [NFU-1:0]                 res_valid,
  output logic [NFU-1:0]                 busy,
  output logic                           conflict,
  output logic [NFU-1:0]                 overrun
);
  localparam int FIW = DSTW - 1;

  logic [NFU-1:0]           op_we, trig_we;
  logic [NFU-1:0][DW-1:0]   op_wdata, trig_data;
  logic [NFU-1:0][2:0]      trig_op;
  logic                     dup;

  assign mv_ready = ~stall;

  // Route moves to FUs. Buses are scanned high to low so the lowest-index bus
  // naming a destination is the one that sticks.
  always_comb begin
    op_we     = '0;
    op_wdata  = '0;
    trig_we   = '0;
    trig_op   = '0;
    trig_data = '0;
    dup       = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      for (int b = NBUS - 1; b >= 0; b--) begin
        if (mv_valid[b] && !stall && mv_dst[b][DSTW-1:1] == FIW'(i)) begin
          if (mv_dst[b][0]) begin
            trig_we[i]   = 1'b1;
            trig_op[i]   = mv_op[b];
            trig_data[i] = mv_data[b];
          end else begin
            op_we[i]    = 1'b1;
            op_wdata[i] = mv_data[b];
          end
        end
      end
    end
    for (int b = 0; b < NBUS; b++)
      for (int c = b + 1; c < NBUS; c++)
        if (mv_valid[b] && mv_valid[c] && !stall && mv_dst[b] == mv_dst[c] &&
            int'(mv_dst[b][DSTW-1:1]) < NFU)
          dup = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) conflict <= 1'b0;
    else      conflict <= dup;
  end

  tta_fu #(.DW(DW), .LAT(LAT)) u_fu [NFU-1:0] (
    .clk       (clk),
    .rst_n     (rst),
    .stall     (stall),
    .op_we     (op_we),
    .op_wdata  (op_wdata),
    .trig_we   (trig_we),
    .trig_op   (trig_op),
    .trig_data (trig_data),
    .rd_en     (rd_en),
    .res_data  (res_data),
    .res_valid (res_valid),
    .busy      (busy),
    .overrun   (overrun)
  );
endmodule

// File: tb/tb_tta_fu_array.sv
// Bench for tta_fu_array: directed scenarios with hand-derived expectations,
// then random traffic checked against a queue-based reference model.
module tb_tta_fu_array;
  localparam int NBUS = 2, NFU = 4, DW = 32, LAT = 2;
  localparam int DSTW = $clog2(NFU) + 1;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1;

  logic                        clk, rst, stall;
  logic [NBUS-1:0]             mv_valid;
  logic [NBUS-1:0][DSTW-1:0]   mv_dst;
  logic [NBUS-1:0][2:0]        mv_op;
  logic [NBUS-1:0][DW-1:0]     mv_data;
  logic                        mv_ready;
  logic [NFU-1:0]              rd_en;
  logic [NFU-1:0][DW-1:0]      res_data;
  logic [NFU-1:0]              res_valid, busy, overrun;
  logic                        conflict;

  int checks = 0, passes = 0;

  // Reference model state
  logic [DW-1:0]          m_o [NFU];
  logic [DW-1:0]          m_qv [NFU][$];
  int                     m_qa [NFU][$];
  logic [NFU-1:0][DW-1:0] m_rd;
  logic [NFU-1:0]         m_rv, m_ovr, m_busy;
  logic                   m_conf;

  tta_fu_array #(.NBUS(NBUS), .NFU(NFU), .DW(DW), .LAT(LAT), .DSTW(DSTW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .mv_valid(mv_valid), .mv_dst(mv_dst),
    .mv_op(mv_op), .mv_data(mv_data), .mv_ready(mv_ready), .rd_en(rd_en),
    .res_data(res_data), .res_valid(res_valid), .busy(busy),
    .conflict(conflict), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ref_op(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    int sh;
    sh = int'(b % DW);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ($signed(a) < $signed(b)) ? 1 : 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NFU; i++) begin
      m_o[i] = '0; m_qv[i].delete(); m_qa[i].delete();
    end
    m_rd = '0; m_rv = '0; m_ovr = '0; m_busy = '0; m_conf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    logic [DW-1:0] rv;
    bit claimed [NFU][2];
    int fu, pt;
    for (int i = 0; i < NFU; i++) begin
      bit ret = 0;
      if (!stall) begin
        for (int j = 0; j < m_qa[i].size(); j++) m_qa[i][j]++;
        if (m_qa[i].size() > 0 && m_qa[i][0] == LAT) begin
          ret = 1; rv = m_qv[i].pop_front(); void'(m_qa[i].pop_front());
        end
      end
      if (ret) begin
        if (m_rv[i] && !rd_en[i]) m_ovr[i] = 1'b1;
        m_rv[i] = 1'b1; m_rd[i] = rv;
      end else if (rd_en[i]) m_rv[i] = 1'b0;
      claimed[i][0] = 0; claimed[i][1] = 0;
    end
    m_conf = 1'b0;
    if (!stall) begin
      // operand moves land first so a same-cycle trigger sees the new value
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < NBUS; b++) begin
          fu = int'(mv_dst[b]) / 2; pt = int'(mv_dst[b]) % 2;
          if (mv_valid[b] && pt == p && fu < NFU) begin
            if (claimed[fu][pt]) m_conf = 1'b1;
            else begin
              claimed[fu][pt] = 1;
              if (pt == 0) m_o[fu] = mv_data[b];
              else begin
                m_qv[fu].push_back(ref_op(mv_op[b], m_o[fu], mv_data[b]));
                m_qa[fu].push_back(0);
              end
            end
          end
        end
    end
    for (int i = 0; i < NFU; i++) m_busy[i] = (m_qa[i].size() > 0);
  endtask

  task automatic tick();
    if (rst) model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_moves();
    mv_valid = '0; mv_dst = '0; mv_op = '0; mv_data = '0;
  endtask

  task automatic set_mv(int b, int fu, int pt, logic [2:0] op, logic [DW-1:0] d);
    mv_valid[b] = 1'b1;
    mv_dst[b]   = DSTW'(fu * 2 + pt);
    mv_op[b]    = op;
    mv_data[b]  = d;
  endtask

  task automatic apply_reset();
    rst = 1'b0; stall = 1'b0; rd_en = '0;
    clear_moves();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (res_valid !== '0 || busy !== '0 || overrun !== '0 || conflict !== 1'b0)
      $display("FAIL reset_flags: valid=%b busy=%b ovr=%b conf=%b want 0", res_valid, busy, overrun, conflict);
    else passes++;
    checks++; if (res_data !== '0) $display("FAIL reset_data: got %h want 0", res_data); else passes++;
    checks++; if (mv_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mv_ready); else passes++;
  endtask

  task automatic test_add();
    apply_reset();
    set_mv(0, 0, 0, ADD, 5); tick(); clear_moves();
    set_mv(0, 0, 1, ADD, 3); tick(); clear_moves();
    checks++; if (busy[0] !== 1'b1) $display("FAIL add_busy: got %b want 1", busy[0]); else passes++;
    repeat (LAT - 1) tick();
    checks++; if (res_valid[0] !== 1'b0) $display("FAIL add_early: got %b want 0", res_valid[0]); else passes++;
    tick();
    checks++; if (res_data[0] !== 32'd8 || res_valid[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL add_result: got %0d v%b b%b want 8 v1 b0", res_data[0], res_valid[0], busy[0]);
    else passes++;
    rd_en[0] = 1'b1; tick(); rd_en = '0;
    checks++; if (res_valid[0] !== 1'b0) $display("FAIL add_consume: got %b want 0", res_valid[0]); else passes++;
  endtask

  task automatic test_bypass();
    apply_reset();
    set_mv(1, 2, 0, ADD, 10); set_mv(0, 2, 1, SUB, 4); tick(); clear_moves();
    repeat (LAT) tick();
    checks++; if (res_data[2] !== 32'd6) $display("FAIL bypass_sub: got %0d want 6", res_data[2]); else passes++;
    rd_en[2] = 1'b1;
    set_mv(0, 2, 1, ADD, 0); tick(); clear_moves(); rd_en = '0;
    repeat (LAT) tick();
    checks++; if (res_data[2] !== 32'd10) $display("FAIL bypass_keep: got %0d want 10", res_data[2]); else passes++;
  endtask

  task automatic test_conflict();
    apply_reset();
    set_mv(0, 1, 0, ADD, 0); tick(); clear_moves();
    checks++; if (conflict !== 1'b0) $display("FAIL conflict_idle: got %b want 0", conflict); else passes++;
    set_mv(0, 1, 1, ADD, 1); set_mv(1, 1, 1, ADD, 2); tick(); clear_moves();
    checks++; if (conflict !== 1'b1) $display("FAIL conflict_pulse: got %b want 1", conflict); else passes++;
    tick();
    checks++; if (conflict !== 1'b0) $display("FAIL conflict_drop: got %b want 0", conflict); else passes++;
    repeat (LAT - 1) tick();
    checks++; if (res_data[1] !== 32'd1 || res_valid[1] !== 1'b1)
      $display("FAIL conflict_winner: got %0d v%b want 1 v1", res_data[1], res_valid[1]);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] base, d [4];
    apply_reset();
    base = $urandom;
    set_mv(0, 0, 0, ADD, base); tick(); clear_moves();
    for (int k = 0; k < 4; k++) d[k] = $urandom;
    rd_en[0] = 1'b1;
    for (int t = 1; t <= 4 + LAT; t++) begin
      if (t <= 4) set_mv(0, 0, 1, ADD, d[t-1]);
      tick(); clear_moves();
      if (t > LAT) begin
        checks++; if (res_data[0] !== base + d[t-LAT-1] || res_valid[0] !== 1'b1)
          $display("FAIL b2b_order%0d: got %h v%b want %h v1", t - LAT, res_data[0], res_valid[0], base + d[t-LAT-1]);
        else passes++;
      end
    end
    checks++; if (overrun[0] !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", overrun[0]); else passes++;
    tick(); rd_en = '0;
    for (int t = 1; t <= 4 + LAT; t++) begin
      if (t <= 4) set_mv(0, 0, 1, ADD, d[t-1]);
      tick(); clear_moves();
    end
    checks++; if (overrun[0] !== 1'b1 || res_data[0] !== base + d[3])
      $display("FAIL b2b_overrun: got %b %h want 1 %h", overrun[0], res_data[0], base + d[3]);
    else passes++;
    rd_en[0] = 1'b1; repeat (3) tick(); rd_en = '0;
    checks++; if (overrun[0] !== 1'b1) $display("FAIL b2b_sticky: got %b want 1", overrun[0]); else passes++;
  endtask

  task automatic test_stall();
    apply_reset();
    set_mv(0, 3, 0, ADD, 7); tick(); clear_moves();
    set_mv(0, 3, 1, ADD, 7); tick(); clear_moves();
    stall = 1'b1;
    set_mv(0, 3, 0, ADD, 100); set_mv(1, 3, 1, ADD, 1);
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (mv_ready !== 1'b0 || res_valid[3] !== 1'b0 || busy[3] !== 1'b1)
        $display("FAIL stall_hold%0d: rdy%b v%b b%b want 0 0 1", s, mv_ready, res_valid[3], busy[3]);
      else passes++;
    end
    stall = 1'b0; clear_moves();
    repeat (LAT - 1) tick();
    checks++; if (res_valid[3] !== 1'b0) $display("FAIL stall_early: got %b want 0", res_valid[3]); else passes++;
    tick();
    checks++; if (res_data[3] !== 32'd14 || res_valid[3] !== 1'b1 || busy[3] !== 1'b0)
      $display("FAIL stall_result: got %0d v%b b%b want 14 v1 b0", res_data[3], res_valid[3], busy[3]);
    else passes++;
    rd_en[3] = 1'b1;
    set_mv(0, 3, 1, ADD, 0); tick(); clear_moves(); rd_en = '0;
    repeat (LAT) tick();
    checks++; if (res_data[3] !== 32'd7) $display("FAIL stall_dropped: got %0d want 7", res_data[3]); else passes++;
  endtask

  task automatic test_reset_flight();
    apply_reset();
    set_mv(0, 1, 1, ADD, 33); tick(); clear_moves();
    repeat (LAT) tick();
    set_mv(0, 0, 1, ADD, 9); tick(); clear_moves();
    #2 rst = 1'b0;
    #1;
    model_reset();
    checks++; if (res_valid !== '0 || busy !== '0 || res_data !== '0 || overrun !== '0 || conflict !== 1'b0)
      $display("FAIL rstfl_now: v%b b%b d%h want all 0", res_valid, busy, res_data);
    else passes++;
    @(posedge clk); #1 rst = 1'b1;
    repeat (LAT + 2) tick();
    checks++; if (res_valid !== '0 || busy !== '0 || res_data !== '0)
      $display("FAIL rstfl_ghost: v%b b%b d%h want all 0", res_valid, busy, res_data);
    else passes++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 9) == 0);
      rd_en = NFU'($urandom);
      clear_moves();
      for (int b = 0; b < NBUS; b++)
        if ($urandom_range(0, 9) < 6)
          set_mv(b, int'($urandom_range(0, NFU - 1)), int'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom));
      tick();
      checks++; if (res_data !== m_rd) $display("FAIL rnd_data c%0d: got %h want %h", c, res_data, m_rd); else passes++;
      checks++; if (res_valid !== m_rv) $display("FAIL rnd_valid c%0d: got %b want %b", c, res_valid, m_rv); else passes++;
      checks++; if (busy !== m_busy) $display("FAIL rnd_busy c%0d: got %b want %b", c, busy, m_busy); else passes++;
      checks++; if (overrun !== m_ovr) $display("FAIL rnd_overrun c%0d: got %b want %b", c, overrun, m_ovr); else passes++;
      checks++; if (conflict !== m_conf) $display("FAIL rnd_conflict c%0d: got %b want %b", c, conflict, m_conf); else passes++;
      checks++; if (mv_ready !== ~stall) $display("FAIL rnd_ready c%0d: got %b want %b", c, mv_ready, ~stall); else passes++;
    end
    clear_moves(); stall = 1'b0; rd_en = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; rd_en = '0;
    clear_moves();
    model_reset();
    test_reset();
    test_add();
    test_bypass();
    test_conflict();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1);
  end
endmodule
